// File: rtl/wb_periph_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_periph_arbiter_if
// One pipelined Wishbone link. The master modport is the side that issues
// cycles; the slave modport is the side that answers them. The arbiter takes
// two links as a slave (one per master) and one link as a master (to the
// peripheral register slave).
// -----------------------------------------------------------------------------
interface wb_periph_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [SEL_W-1:0]  sel;
   logic              stall;
   logic              ack;
   logic              err;
   logic [DATA_W-1:0] rdata;

   modport master (
      output cyc, stb, we, addr, wdata, sel,
      input  stall, ack, err, rdata
   );

   modport slave (
      input  cyc, stb, we, addr, wdata, sel,
      output stall, ack, err, rdata
   );
endinterface

// File: rtl/wb_periph_arbiter.sv
// -----------------------------------------------------------------------------
// wb_periph_arbiter
// Two-master pipelined Wishbone arbiter in front of the peripheral register
// slave. Master 0 is the CPU data port, master 1 the audio sample streamer.
// Ownership is granted round-robin from IDLE and held until the owner drops
// cyc. Accepted-but-unacked transfers are counted so that acks are only
// forwarded while something is outstanding and the owner is throttled at
// MAX_OUTST. A transfer that stays unacked for TIMEOUT_CYC cycles is aborted
// with a one-cycle error pulse to the owner.
// -----------------------------------------------------------------------------
module wb_periph_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_OUTST   = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   wb_periph_arbiter_if.slave  m0,
   wb_periph_arbiter_if.slave  m1,
   wb_periph_arbiter_if.master s
);
   localparam int          SEL_W = DATA_W / 8;
   localparam logic [3:0]  MAX_C = 4'(MAX_OUTST);
   localparam logic [15:0] TMO_C = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // last_r doubles as the owner index: it is written on every grant, so
   // while in OWN0/OWN1/ERR it names the master holding the bus.
   state_t      state_r;
   logic        last_r;
   logic [3:0]  outst_r;
   logic [15:0] tmo_r;

   logic              own_s;
   logic              own_cyc_s;
   logic              own_stb_s;
   logic              own_we_s;
   logic [ADDR_W-1:0] own_addr_s;
   logic [DATA_W-1:0] own_wdata_s;
   logic [SEL_W-1:0]  own_sel_s;
   logic              room_s;
   logic              s_stb_s;
   logic              accept_s;
   logic              ack_ok_s;
   logic              tmo_run_s;
   logic              tmo_hit_s;
   logic [3:0]        outst_nxt_s;

   // Owner request mux plus the accept / ack / timeout bookkeeping terms
   always_comb begin
      own_s = (state_r == ST_OWN0) || (state_r == ST_OWN1);
      if (last_r) begin
         own_cyc_s   = m1.cyc;
         own_stb_s   = m1.stb;
         own_we_s    = m1.we;
         own_addr_s  = m1.addr;
         own_wdata_s = m1.wdata;
         own_sel_s   = m1.sel;
      end else begin
         own_cyc_s   = m0.cyc;
         own_stb_s   = m0.stb;
         own_we_s    = m0.we;
         own_addr_s  = m0.addr;
         own_wdata_s = m0.wdata;
         own_sel_s   = m0.sel;
      end
      room_s      = (outst_r < MAX_C);
      s_stb_s     = own_s & own_stb_s & room_s;
      accept_s    = s_stb_s & ~s.stall;
      // An ack with nothing outstanding is stray and must not underflow.
      ack_ok_s    = own_s & s.ack & (outst_r != 4'd0);
      tmo_run_s   = own_s & (outst_r != 4'd0) & ~s.ack;
      tmo_hit_s   = tmo_run_s & ((tmo_r + 16'd1) == TMO_C);
      outst_nxt_s = outst_r + 4'(accept_s) - 4'(ack_ok_s);
   end

   // Ownership FSM with outstanding-transfer counter and ack timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         last_r  <= 1'b1;
         outst_r <= 4'd0;
         tmo_r   <= 16'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               outst_r <= 4'd0;
               tmo_r   <= 16'd0;
               if (m0.cyc && m1.cyc) begin
                  // Tie: hand the bus to whoever did not have it last.
                  if (last_r) begin
                     state_r <= ST_OWN0;
                     last_r  <= 1'b0;
                  end else begin
                     state_r <= ST_OWN1;
                     last_r  <= 1'b1;
                  end
               end else if (m0.cyc) begin
                  state_r <= ST_OWN0;
                  last_r  <= 1'b0;
               end else if (m1.cyc) begin
                  state_r <= ST_OWN1;
                  last_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_OWN0, ST_OWN1: begin
               if (!own_cyc_s) begin
                  // Owner released; anything still in flight is forgotten.
                  state_r <= ST_IDLE;
                  outst_r <= 4'd0;
                  tmo_r   <= 16'd0;
               end else if (tmo_hit_s) begin
                  state_r <= ST_ERR;
                  outst_r <= 4'd0;
                  tmo_r   <= 16'd0;
               end else begin
                  outst_r <= outst_nxt_s;
                  tmo_r   <= tmo_run_s ? (tmo_r + 16'd1) : 16'd0;
               end
            end
            ST_ERR: begin
               state_r <= ST_IDLE;
               outst_r <= 4'd0;
               tmo_r   <= 16'd0;
            end
            default: begin
               state_r <= ST_IDLE;
               outst_r <= 4'd0;
               tmo_r   <= 16'd0;
            end
         endcase
      end
   end

   // Slave-side request: only driven while a master owns the bus
   assign s.cyc   = own_s;
   assign s.stb   = s_stb_s;
   assign s.we    = own_s & own_we_s;
   assign s.addr  = own_s ? own_addr_s  : {ADDR_W{1'b0}};
   assign s.wdata = own_s ? own_wdata_s : {DATA_W{1'b0}};
   assign s.sel   = own_s ? own_sel_s   : {SEL_W{1'b0}};

   // Master-side responses: non-owners are stalled and see no ack or error
   assign m0.stall = ~((state_r == ST_OWN0) & ~s.stall & room_s);
   assign m1.stall = ~((state_r == ST_OWN1) & ~s.stall & room_s);
   assign m0.ack   = (state_r == ST_OWN0) & ack_ok_s;
   assign m1.ack   = (state_r == ST_OWN1) & ack_ok_s;
   assign m0.err   = (state_r == ST_ERR) & ~last_r;
   assign m1.err   = (state_r == ST_ERR) &  last_r;
   assign m0.rdata = s.rdata;
   assign m1.rdata = s.rdata;

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_periph_arbiter
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic compared every cycle against a transaction-level model of the
// arbiter (who owns the bus, how many transfers are in flight, how long since
// the slave last made progress).
// -----------------------------------------------------------------------------
module tb_wb_periph_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXO = 4;
   localparam int TMO  = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   wb_periph_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
   wb_periph_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
   wb_periph_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

   wb_periph_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if), .s(s_if)
   );

   int checks   = 0;
   int failures = 0;

   // model: owner -1 means nobody; err_pend marks the single error cycle
   int mo_owner, mo_last, mo_outst, mo_quiet, mo_err_who;
   bit mo_err_pend;
   int mn_owner, mn_last, mn_outst, mn_quiet, mn_err_who;
   bit mn_err_pend;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mo_owner = -1; mo_last = 1; mo_outst = 0; mo_quiet = 0; mo_err_who = 0; mo_err_pend = 1'b0;
      mn_owner = -1; mn_last = 1; mn_outst = 0; mn_quiet = 0; mn_err_who = 0; mn_err_pend = 1'b0;
   endtask

   task automatic clear_inputs();
      m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
      m0_if.addr = 32'd0; m0_if.wdata = 32'd0; m0_if.sel = 4'd0;
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
      m1_if.addr = 32'd0; m1_if.wdata = 32'd0; m1_if.sel = 4'd0;
      s_if.stall = 1'b0; s_if.ack = 1'b0; s_if.err = 1'b0; s_if.rdata = 32'd0;
   endtask

   // Compare DUT outputs with the model at the falling edge, then work out
   // what the model looks like after the coming rising edge.
   task automatic sample();
      logic [1:0] cyc_v, stb_v;
      logic [AW-1:0] o_addr;
      logic [DW-1:0] o_wdata;
      logic [3:0]    o_sel;
      logic          o_we;
      logic          act_stall, act_ack, act_err;
      bit e_scyc, e_sstb, e_stall, e_ack, e_err, acc, ackv;
      int own, win;
      @(negedge clk);
      cyc_v = {m1_if.cyc, m0_if.cyc};
      stb_v = {m1_if.stb, m0_if.stb};
      own   = mo_owner;
      e_scyc = (own >= 0);
      e_sstb = (own >= 0) && stb_v[own] && (mo_outst < MAXO);
      chk("s_cyc", s_if.cyc, e_scyc);
      chk("s_stb", s_if.stb, e_sstb);
      if (own >= 0) begin
         o_addr  = (own == 1) ? m1_if.addr  : m0_if.addr;
         o_wdata = (own == 1) ? m1_if.wdata : m0_if.wdata;
         o_sel   = (own == 1) ? m1_if.sel   : m0_if.sel;
         o_we    = (own == 1) ? m1_if.we    : m0_if.we;
         chk("s_addr", s_if.addr, o_addr);
         chk("s_wdata", s_if.wdata, o_wdata);
         chk("s_sel", s_if.sel, o_sel);
         chk("s_we", s_if.we, o_we);
      end
      for (int x = 0; x < 2; x++) begin
         e_stall = !(own == x) || s_if.stall || (mo_outst == MAXO);
         e_ack   = (own == x) && s_if.ack && (mo_outst > 0);
         e_err   = mo_err_pend && (mo_err_who == x);
         act_stall = (x == 1) ? m1_if.stall : m0_if.stall;
         act_ack   = (x == 1) ? m1_if.ack   : m0_if.ack;
         act_err   = (x == 1) ? m1_if.err   : m0_if.err;
         chk($sformatf("m%0d_stall", x), act_stall, e_stall);
         chk($sformatf("m%0d_ack", x), act_ack, e_ack);
         chk($sformatf("m%0d_err", x), act_err, e_err);
      end
      chk("m0_rdata", m0_if.rdata, s_if.rdata);
      chk("m1_rdata", m1_if.rdata, s_if.rdata);

      mn_owner = mo_owner; mn_last = mo_last; mn_outst = mo_outst;
      mn_quiet = mo_quiet; mn_err_who = mo_err_who; mn_err_pend = mo_err_pend;
      if (mo_err_pend) begin
         mn_err_pend = 1'b0; mn_owner = -1; mn_outst = 0; mn_quiet = 0;
      end else if (own < 0) begin
         if (cyc_v == 2'b11) win = 1 - mo_last;
         else if (cyc_v[0]) win = 0;
         else if (cyc_v[1]) win = 1;
         else win = -1;
         if (win >= 0) begin
            mn_owner = win; mn_last = win;
         end
         mn_outst = 0; mn_quiet = 0;
      end else if (!cyc_v[own]) begin
         mn_owner = -1; mn_outst = 0; mn_quiet = 0;
      end else begin
         acc  = e_sstb && !s_if.stall;
         ackv = s_if.ack && (mo_outst > 0);
         if (mo_outst > 0 && !s_if.ack) mn_quiet = mo_quiet + 1;
         else mn_quiet = 0;
         if (mn_quiet == TMO) begin
            mn_err_pend = 1'b1; mn_err_who = own; mn_owner = -1; mn_outst = 0; mn_quiet = 0;
         end else begin
            mn_outst = mo_outst + int'(acc) - int'(ackv);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset_n) begin
         mo_owner = mn_owner; mo_last = mn_last; mo_outst = mn_outst;
         mo_quiet = mn_quiet; mo_err_who = mn_err_who; mo_err_pend = mn_err_pend;
      end else begin
         model_reset();
      end
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      model_reset();
      sample(); advance();
      sample(); advance();
      reset_n = 1'b1;
   endtask

   function automatic logic next_cyc(logic cur);
      if (cur) return ($urandom_range(15) != 0);
      else     return ($urandom_range(2) == 0);
   endfunction

   int n_acc;

   initial begin
      model_reset();
      clear_inputs();
      #1;

      // 1: reset holds the bus idle even with m0 requesting
      m0_if.cyc = 1'b1;
      sample();
      chk("t1_rst_s_cyc", s_if.cyc, 64'd0);
      chk("t1_rst_m0_stall", m0_if.stall, 64'd1);
      chk("t1_rst_m0_ack", m0_if.ack, 64'd0);
      advance();
      reset_n = 1'b1;
      sample();
      chk("t1_idle_s_cyc", s_if.cyc, 64'd0);
      advance();
      sample();
      chk("t1_own_s_cyc", s_if.cyc, 64'd1);
      chk("t1_own_m0_stall", m0_if.stall, 64'd0);
      chk("t1_own_m1_stall", m1_if.stall, 64'd1);
      advance();

      // 2: simultaneous request after reset -> m0, then m1 once m0 leaves
      do_reset();
      m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
      sample(); advance();
      sample();
      chk("t2_own0_s_cyc", s_if.cyc, 64'd1);
      chk("t2_own0_m0_stall", m0_if.stall, 64'd0);
      chk("t2_own0_m1_stall", m1_if.stall, 64'd1);
      advance();
      m0_if.cyc = 1'b0;
      sample(); advance();
      sample();
      chk("t2_idle_s_cyc", s_if.cyc, 64'd0);
      advance();
      m1_if.stb = 1'b1; m1_if.addr = 32'h0000_1234;
      sample();
      chk("t2_own1_s_cyc", s_if.cyc, 64'd1);
      chk("t2_own1_m1_stall", m1_if.stall, 64'd0);
      chk("t2_own1_s_stb", s_if.stb, 64'd1);
      chk("t2_own1_s_addr", s_if.addr, 64'h1234);
      advance();
      m1_if.stb = 1'b0; m1_if.cyc = 1'b0;
      sample(); advance();

      // 3: no acks, six strobes -> four accepted, stall from the fifth
      do_reset();
      m0_if.cyc = 1'b1;
      sample(); advance();
      n_acc = 0;
      for (int k = 1; k <= 6; k++) begin
         m0_if.stb = 1'b1; m0_if.addr = $urandom; m0_if.wdata = $urandom;
         sample();
         if (s_if.stb && !s_if.stall) n_acc++;
         chk($sformatf("t3_m0_stall_%0d", k), m0_if.stall, (k >= 5) ? 64'd1 : 64'd0);
         advance();
      end
      chk("t3_accepted", 64'(n_acc), 64'd4);
      m0_if.stb = 1'b0; m0_if.cyc = 1'b0;
      sample(); advance();

      // 4: accept and ack together at outst=2 keeps the count at 2
      do_reset();
      m0_if.cyc = 1'b1;
      sample(); advance();
      m0_if.stb = 1'b1;
      repeat (2) begin sample(); advance(); end
      s_if.ack = 1'b1;
      sample();
      chk("t4_m0_ack", m0_if.ack, 64'd1);
      chk("t4_m1_ack", m1_if.ack, 64'd0);
      chk("t4_s_stb", s_if.stb, 64'd1);
      advance();
      s_if.ack = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         sample();
         chk($sformatf("t4_m0_stall_%0d", k), m0_if.stall, (k == 3) ? 64'd1 : 64'd0);
         advance();
      end
      m0_if.stb = 1'b0; m0_if.cyc = 1'b0;
      sample(); advance();

      // 5: one transfer never acked -> error pulse 8 cycles after accept
      do_reset();
      m0_if.cyc = 1'b1;
      sample(); advance();
      m0_if.stb = 1'b1;
      sample();
      chk("t5_accept", 64'(s_if.stb & ~s_if.stall), 64'd1);
      advance();
      m0_if.stb = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         sample();
         chk($sformatf("t5_m0_err_%0d", k), m0_if.err, (k == 9) ? 64'd1 : 64'd0);
         chk($sformatf("t5_s_cyc_%0d", k), s_if.cyc, (k == 9 || k == 10) ? 64'd0 : 64'd1);
         chk($sformatf("t5_m1_err_%0d", k), m1_if.err, 64'd0);
         advance();
      end
      m0_if.stb = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         sample();
         chk($sformatf("t5_regrant_stall_%0d", k), m0_if.stall, 64'd0);
         advance();
      end
      m0_if.stb = 1'b0; m0_if.cyc = 1'b0;
      sample(); advance();

      // 6: async reset mid-OWN1 with three in flight, then a late ack
      do_reset();
      m1_if.cyc = 1'b1;
      sample(); advance();
      m1_if.stb = 1'b1;
      repeat (3) begin sample(); advance(); end
      m1_if.stb = 1'b0;
      #1;
      chk("t6_pre_s_cyc", s_if.cyc, 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_async_s_cyc", s_if.cyc, 64'd0);
      chk("t6_async_m1_stall", m1_if.stall, 64'd1);
      model_reset();
      sample(); advance();
      reset_n = 1'b1; m1_if.cyc = 1'b0; s_if.ack = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         sample();
         chk($sformatf("t6_late_m0_ack_%0d", k), m0_if.ack, 64'd0);
         chk($sformatf("t6_late_m1_ack_%0d", k), m1_if.ack, 64'd0);
         advance();
      end
      s_if.ack = 1'b0;

      // randomized traffic, alternating chatty and sluggish slave phases
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         m0_if.cyc   = next_cyc(m0_if.cyc);
         m0_if.stb   = m0_if.cyc && ($urandom_range(3) != 0);
         m0_if.we    = 1'($urandom_range(1));
         m0_if.addr  = $urandom;
         m0_if.wdata = $urandom;
         m0_if.sel   = 4'($urandom_range(15));
         m1_if.cyc   = next_cyc(m1_if.cyc);
         m1_if.stb   = m1_if.cyc && ($urandom_range(3) != 0);
         m1_if.we    = 1'($urandom_range(1));
         m1_if.addr  = $urandom;
         m1_if.wdata = $urandom;
         m1_if.sel   = 4'($urandom_range(15));
         s_if.stall  = ($urandom_range(3) == 0);
         s_if.ack    = (((i / 300) % 2) == 0) ? ($urandom_range(1) == 1)
                                              : ($urandom_range(19) == 0);
         s_if.rdata  = $urandom;
         sample();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
